execute_stage_mc: RTL

Parametrised next-generation execute stage for the RISC pipeline. It owns the carry/zero (CZ) flag register and resolves operand forwarding from FWD_N sources at issue. It executes single-cycle ALU ops and conditional ADC/ADZ/NDC/NDZ, plus an iterative multi-cycle MUL. It sits between register-read and memory stages with valid/ready handshakes on both sides, a registered output and a flush input.

---
 rtl/execute_stage_mc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, CZ flag register, single-cycle ALU with
// conditional ops, and an iterative shift-add multiplier behind valid/ready.
module execute_stage_mc #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int FWD_N      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_op,
  input  logic [REG_ADDR_W-1:0]       in_rs1,
  input  logic [REG_ADDR_W-1:0]       in_rs2,
  input  logic [DATA_W-1:0]           in_rs1_data,
  input  logic [DATA_W-1:0]           in_rs2_data,
  input  logic                        in_imm_sel,
  input  logic [DATA_W-1:0]           in_imm,
  input  logic [REG_ADDR_W-1:0]       in_dest,
  input  logic [FWD_N-1:0]            fwd_valid,
  input  logic [FWD_N*REG_ADDR_W-1:0] fwd_dest,
  input  logic [FWD_N*DATA_W-1:0]     fwd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_result,
  output logic [REG_ADDR_W-1:0]       out_dest,
  output logic                        out_wr_en,
  output logic [1:0]                  out_cz
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADC  = 3'd1;
  localparam logic [2:0] OP_ADZ  = 3'd2;
  localparam logic [2:0] OP_NDU  = 3'd3;
  localparam logic [2:0] OP_NDC  = 3'd4;
  localparam logic [2:0] OP_NDZ  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic                    out_valid_r, out_valid_nxt_s;
  logic [DATA_W-1:0]       out_result_r, out_result_nxt_s;
  logic [REG_ADDR_W-1:0]   out_dest_r, out_dest_nxt_s;
  logic                    out_wr_en_r, out_wr_en_nxt_s;
  logic [1:0]              cz_r, cz_nxt_s;
  logic [CNT_W-1:0]        mul_cnt_r, mul_cnt_nxt_s;
  logic [2*DATA_W-1:0]     mul_acc_r, mul_acc_nxt_s;
  logic [2*DATA_W-1:0]     mul_mcand_r, mul_mcand_nxt_s;
  logic [DATA_W-1:0]       mul_mplier_r, mul_mplier_nxt_s;
  logic [REG_ADDR_W-1:0]   mul_dest_r, mul_dest_nxt_s;

  logic                    in_ready_s;
  logic                    accept_s;
  logic [DATA_W-1:0]       opa_s, opb_fwd_s, opb_s;
  logic [DATA_W:0]         sum_s;
  logic [DATA_W-1:0]       nand_s;
  logic                    cond_s;
  logic [DATA_W-1:0]       alu_res_s;
  logic                    alu_wr_s;
  logic [1:0]              alu_cz_s;
  logic [2*DATA_W-1:0]     mul_step_s;
  logic                    mul_last_s;

  assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !flush;
  assign accept_s   = in_valid && in_ready_s;
  assign mul_step_s = mul_mplier_r[0] ? (mul_acc_r + mul_mcand_r) : mul_acc_r;
  assign mul_last_s = (state_r == ST_MUL_BUSY) && (mul_cnt_r == {CNT_W{1'b0}});

  // Operand resolution: walk sources oldest-first so the youngest match wins.
  always_comb begin
    opa_s     = in_rs1_data;
    opb_fwd_s = in_rs2_data;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      opa_s = (fwd_valid[i] && (fwd_dest[i*REG_ADDR_W +: REG_ADDR_W] == in_rs1))
              ? fwd_data[i*DATA_W +: DATA_W] : opa_s;
      opb_fwd_s = (fwd_valid[i] && (fwd_dest[i*REG_ADDR_W +: REG_ADDR_W] == in_rs2))
                  ? fwd_data[i*DATA_W +: DATA_W] : opb_fwd_s;
    end
    opb_s = in_imm_sel ? in_imm : opb_fwd_s;
  end

  // Single-cycle ALU result, write enable and flag outcome against current CZ.
  always_comb begin
    sum_s     = {1'b0, opa_s} + {1'b0, opb_s};
    nand_s    = ~(opa_s & opb_s);
    alu_res_s = opa_s;
    alu_wr_s  = 1'b1;
    alu_cz_s  = cz_r;
    case (in_op)
      OP_ADC, OP_NDC: cond_s = cz_r[0];
      OP_ADZ, OP_NDZ: cond_s = cz_r[1];
      default:        cond_s = 1'b1;
    endcase
    case (in_op)
      OP_ADD, OP_ADC, OP_ADZ: begin
        alu_res_s = sum_s[DATA_W-1:0];
        if (cond_s) begin
          alu_cz_s = {(sum_s[DATA_W-1:0] == {DATA_W{1'b0}}), sum_s[DATA_W]};
        end else begin
          alu_wr_s = 1'b0;
        end
      end
      OP_NDU, OP_NDC, OP_NDZ: begin
        alu_res_s = nand_s;
        if (cond_s) begin
          alu_cz_s = {(nand_s == {DATA_W{1'b0}}), cz_r[0]};
        end else begin
          alu_wr_s = 1'b0;
        end
      end
      OP_PASS: alu_res_s = opa_s;
      default: alu_res_s = opa_s;
    endcase
  end

  // Next-state logic; flush outranks MUL progress, accept and drain.
  always_comb begin
    state_nxt_s      = state_r;
    out_valid_nxt_s  = out_valid_r;
    out_result_nxt_s = out_result_r;
    out_dest_nxt_s   = out_dest_r;
    out_wr_en_nxt_s  = out_wr_en_r;
    cz_nxt_s         = cz_r;
    mul_cnt_nxt_s    = mul_cnt_r;
    mul_acc_nxt_s    = mul_acc_r;
    mul_mcand_nxt_s  = mul_mcand_r;
    mul_mplier_nxt_s = mul_mplier_r;
    mul_dest_nxt_s   = mul_dest_r;
    if (flush) begin
      state_nxt_s     = ST_IDLE;
      out_valid_nxt_s = 1'b0;
    end else if (state_r == ST_MUL_BUSY) begin
      mul_acc_nxt_s    = mul_step_s;
      mul_mcand_nxt_s  = {mul_mcand_r[2*DATA_W-2:0], 1'b0};
      mul_mplier_nxt_s = {1'b0, mul_mplier_r[DATA_W-1:1]};
      mul_cnt_nxt_s    = mul_cnt_r - CNT_W'(1);
      if (mul_last_s) begin
        state_nxt_s      = ST_IDLE;
        out_valid_nxt_s  = 1'b1;
        out_result_nxt_s = mul_step_s[DATA_W-1:0];
        out_dest_nxt_s   = mul_dest_r;
        out_wr_en_nxt_s  = 1'b1;
        cz_nxt_s = {(mul_step_s[DATA_W-1:0] == {DATA_W{1'b0}}),
                    (mul_step_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}})};
      end else begin
        state_nxt_s = ST_MUL_BUSY;
      end
    end else if (accept_s) begin
      if (in_op == OP_MUL) begin
        // Accepting a MUL also retires any result being drained this edge.
        state_nxt_s      = ST_MUL_BUSY;
        out_valid_nxt_s  = 1'b0;
        mul_cnt_nxt_s    = CNT_W'(DATA_W - 1);
        mul_acc_nxt_s    = {(2*DATA_W){1'b0}};
        mul_mcand_nxt_s  = {{DATA_W{1'b0}}, opa_s};
        mul_mplier_nxt_s = opb_s;
        mul_dest_nxt_s   = in_dest;
      end else begin
        out_valid_nxt_s  = 1'b1;
        out_result_nxt_s = alu_res_s;
        out_dest_nxt_s   = in_dest;
        out_wr_en_nxt_s  = alu_wr_s;
        cz_nxt_s         = alu_cz_s;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output, flag and multiplier datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {DATA_W{1'b0}};
      out_dest_r   <= {REG_ADDR_W{1'b0}};
      out_wr_en_r  <= 1'b0;
      cz_r         <= 2'b00;
      mul_cnt_r    <= {CNT_W{1'b0}};
      mul_acc_r    <= {(2*DATA_W){1'b0}};
      mul_mcand_r  <= {(2*DATA_W){1'b0}};
      mul_mplier_r <= {DATA_W{1'b0}};
      mul_dest_r   <= {REG_ADDR_W{1'b0}};
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_result_r <= out_result_nxt_s;
      out_dest_r   <= out_dest_nxt_s;
      out_wr_en_r  <= out_wr_en_nxt_s;
      cz_r         <= cz_nxt_s;
      mul_cnt_r    <= mul_cnt_nxt_s;
      mul_acc_r    <= mul_acc_nxt_s;
      mul_mcand_r  <= mul_mcand_nxt_s;
      mul_mplier_r <= mul_mplier_nxt_s;
      mul_dest_r   <= mul_dest_nxt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_dest   = out_dest_r;
  assign out_wr_en  = out_wr_en_r;
  assign out_cz     = cz_r;

endmodule
